// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: 32x32 shift-add sequential multiplier with pipeline stall handshake.
// Build option: define MULT_SIGNED_EN to make funct 011000 (mult) a two's-complement multiply.
module mult_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  ALUop,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // state | meaning
    // IDLE  | waiting for a valid mult/multu request
    // BUSY  | one shift-add step per cycle, 32 steps
    // DONE  | result on hi/lo, done pulse; may accept the next request
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    state_t      state, state_nxt;
    logic [31:0] mcand;
    logic [63:0] acc;
    logic [5:0]  cnt;
    logic        valid, accept, last_step;
    logic [32:0] sum;
    logic [63:0] acc_step, product;
    logic [31:0] a_load, b_load;

    assign valid     = start && (ALUop == 2'b10) && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
    assign accept    = valid && ((state == IDLE) || (state == DONE));
    assign last_step = (state == BUSY) && (cnt == 6'd31);

    // Multiplier rides in the low half of the accumulator and is consumed as product bits shift in.
    assign sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign acc_step = {sum, acc[31:1]};

`ifdef MULT_SIGNED_EN
    logic is_signed, neg_load, neg;

    assign is_signed = (funct == FUNCT_MULT);
    assign a_load    = (is_signed && op_a[31]) ? 32'd0 - op_a : op_a;
    assign b_load    = (is_signed && op_b[31]) ? 32'd0 - op_b : op_b;
    assign neg_load  = is_signed && (op_a[31] ^ op_b[31]);
    assign product   = neg ? 64'd0 - acc_step : acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            neg <= 1'b0;
        else if (accept)
            neg <= neg_load;
    end
`else
    assign a_load  = op_a;
    assign b_load  = op_b;
    assign product = acc_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= 32'd0;
            acc   <= 64'd0;
            cnt   <= 6'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            if (accept) begin
                mcand <= a_load;
                acc   <= {32'd0, b_load};
                cnt   <= 6'd0;
            end else if (state == BUSY) begin
                acc <= acc_step;
                cnt <= cnt + 6'd1;
            end
            // Result registers take the final step directly so done lines up with DONE entry.
            if (last_step) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
        end
    end

    assign busy  = (state == BUSY);
    assign done  = (state == DONE);
    assign stall = rst_n && (busy || (valid && ((state == IDLE) || (state == DONE))));

endmodule
